ysyx_041514_mem_wb: RTL and testbench

Pipeline register between the memory stage and the write-back stage. It latches the memory-stage result bundle, gated by the stall and flush controls. It also holds a one-entry read-data buffer that captures dcache load data arriving while the pipeline is stalled, and returns it to the memory stage so the load is not re-issued. It emits a registered commit-valid pulse for write-back and difftest.

---
 rtl/ysyx_041514_mem_wb_pkg.sv | 55 +++++
 rtl/ysyx_041514_mem_wb.sv | 114 +++++++++++
 tb/tb_ysyx_041514_mem_wb.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_041514_mem_wb_pkg.sv
// Shared widths, constants and helper types for the mem/wb pipeline register.
package ysyx_041514_mem_wb_pkg;

  localparam int XLEN              = 64;
  localparam int INST_LEN          = 32;
  localparam int REG_ADDRWIDTH     = 5;
  localparam int CSR_REG_ADDRWIDTH = 12;
  localparam int TRAP_LEN          = 8;

  // addi x0, x0, 0 -- the canonical bubble instruction word
  localparam logic [INST_LEN-1:0] INST_NOP      = 32'h0000_0013;
  localparam logic [TRAP_LEN-1:0] TRAP_BUS_ZERO = '0;

  // What the register does on the next edge
  typedef enum logic [1:0] {
    CTRL_ADVANCE = 2'd0,
    CTRL_STALL   = 2'd1,
    CTRL_FLUSH   = 2'd2
  } ctrl_e;

  // Everything that travels from the memory stage to write-back
  typedef struct packed {
    logic [XLEN-1:0]              pc;
    logic [XLEN-1:0]              mem_data;
    logic [XLEN-1:0]              exc_csr_data;
    logic [INST_LEN-1:0]          inst_data;
    logic [REG_ADDRWIDTH-1:0]     rd_idx;
    logic [CSR_REG_ADDRWIDTH-1:0] csr_addr;
    logic                         exc_csr_valid;
    logic [TRAP_LEN-1:0]          trap_bus;
  } wb_bundle_t;

  // A bubble: no register write, no CSR write, no trap, NOP instruction
  localparam wb_bundle_t BUBBLE = '{
    pc:            '0,
    mem_data:      '0,
    exc_csr_data:  '0,
    inst_data:     INST_NOP,
    rd_idx:        '0,
    csr_addr:      '0,
    exc_csr_valid: 1'b0,
    trap_bus:      TRAP_BUS_ZERO
  };

  // Flush dominates stall, stall dominates advance
  function automatic ctrl_e decode_ctrl(input logic stall, input logic flush);
    if (flush) begin
      return CTRL_FLUSH;
    end else if (stall) begin
      return CTRL_STALL;
    end
    return CTRL_ADVANCE;
  endfunction

endpackage

// File: rtl/ysyx_041514_mem_wb.sv
// Memory -> write-back pipeline register with a one-entry stalled-load data buffer
// and a registered commit pulse.
module ysyx_041514_mem_wb
  import ysyx_041514_mem_wb_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall_valid_i,
  input  logic                         flush_valid_i,
  input  logic                         mem_valid_i,
  input  logic [XLEN-1:0]              pc_i,
  input  logic [XLEN-1:0]              mem_data_i,
  input  logic [XLEN-1:0]              exc_csr_data_i,
  input  logic [INST_LEN-1:0]          inst_data_i,
  input  logic [REG_ADDRWIDTH-1:0]     rd_idx_i,
  input  logic [CSR_REG_ADDRWIDTH-1:0] csr_addr_i,
  input  logic                         exc_csr_valid_i,
  input  logic [TRAP_LEN-1:0]          trap_bus_i,
  input  logic                         load_valid_i,
  input  logic                         mem_data_ready_i,
  output logic                         rdata_buff_valid_o,
  output logic [XLEN-1:0]              rdata_buff_o,
  output logic [XLEN-1:0]              pc_o,
  output logic [XLEN-1:0]              mem_data_o,
  output logic [XLEN-1:0]              exc_csr_data_o,
  output logic [INST_LEN-1:0]          inst_data_o,
  output logic [REG_ADDRWIDTH-1:0]     rd_idx_o,
  output logic [CSR_REG_ADDRWIDTH-1:0] csr_addr_o,
  output logic                         exc_csr_valid_o,
  output logic [TRAP_LEN-1:0]          trap_bus_o,
  output logic                         commit_valid_o
);

  ctrl_e      ctrl;
  wb_bundle_t bundle_in;
  wb_bundle_t bundle_reg;
  logic       commit_reg;
  logic       buff_valid_reg;
  logic [XLEN-1:0] buff_data_reg;
  logic       buff_capture;

  // Decode the edge action and gather the incoming bundle
  always_comb begin
    ctrl         = decode_ctrl(stall_valid_i, flush_valid_i);
    bundle_in    = '{
      pc:            pc_i,
      mem_data:      mem_data_i,
      exc_csr_data:  exc_csr_data_i,
      inst_data:     inst_data_i,
      rd_idx:        rd_idx_i,
      csr_addr:      csr_addr_i,
      exc_csr_valid: exc_csr_valid_i,
      trap_bus:      trap_bus_i
    };
    // Only the first returning load while stalled is kept; the buffer is never overwritten
    buff_capture = load_valid_i & mem_data_ready_i & ~buff_valid_reg;
  end

  // Bundle register and commit pulse: bubble on flush, hold on stall, latch on advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bundle_reg <= BUBBLE;
      commit_reg <= 1'b0;
    end else begin
      case (ctrl)
        CTRL_FLUSH: begin
          bundle_reg <= BUBBLE;
          commit_reg <= 1'b0;
        end
        CTRL_STALL: begin
          commit_reg <= 1'b0;
        end
        default: begin
          bundle_reg <= bundle_in;
          commit_reg <= mem_valid_i;
        end
      endcase
    end
  end

  // Load-data buffer: fills once during a stall, empties on any advance or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buff_valid_reg <= 1'b0;
      buff_data_reg  <= '0;
    end else begin
      case (ctrl)
        CTRL_STALL: begin
          if (buff_capture) begin
            buff_valid_reg <= 1'b1;
            buff_data_reg  <= mem_data_i;
          end
        end
        default: begin
          buff_valid_reg <= 1'b0;
          buff_data_reg  <= '0;
        end
      endcase
    end
  end

  assign pc_o               = bundle_reg.pc;
  assign mem_data_o         = bundle_reg.mem_data;
  assign exc_csr_data_o     = bundle_reg.exc_csr_data;
  assign inst_data_o        = bundle_reg.inst_data;
  assign rd_idx_o           = bundle_reg.rd_idx;
  assign csr_addr_o         = bundle_reg.csr_addr;
  assign exc_csr_valid_o    = bundle_reg.exc_csr_valid;
  assign trap_bus_o         = bundle_reg.trap_bus;
  assign commit_valid_o     = commit_reg;
  assign rdata_buff_valid_o = buff_valid_reg;
  assign rdata_buff_o       = buff_data_reg;

endmodule

// File: tb/tb_ysyx_041514_mem_wb.sv
// Directed table-driven bench for the mem/wb register plus reset and random-stream checks.
module tb_ysyx_041514_mem_wb;
  import ysyx_041514_mem_wb_pkg::*;

  logic                         clk;
  logic                         rst;
  logic                         stall_valid_i;
  logic                         flush_valid_i;
  logic                         mem_valid_i;
  logic [XLEN-1:0]              pc_i;
  logic [XLEN-1:0]              mem_data_i;
  logic [XLEN-1:0]              exc_csr_data_i;
  logic [INST_LEN-1:0]          inst_data_i;
  logic [REG_ADDRWIDTH-1:0]     rd_idx_i;
  logic [CSR_REG_ADDRWIDTH-1:0] csr_addr_i;
  logic                         exc_csr_valid_i;
  logic [TRAP_LEN-1:0]          trap_bus_i;
  logic                         load_valid_i;
  logic                         mem_data_ready_i;
  logic                         rdata_buff_valid_o;
  logic [XLEN-1:0]              rdata_buff_o;
  logic [XLEN-1:0]              pc_o;
  logic [XLEN-1:0]              mem_data_o;
  logic [XLEN-1:0]              exc_csr_data_o;
  logic [INST_LEN-1:0]          inst_data_o;
  logic [REG_ADDRWIDTH-1:0]     rd_idx_o;
  logic [CSR_REG_ADDRWIDTH-1:0] csr_addr_o;
  logic                         exc_csr_valid_o;
  logic [TRAP_LEN-1:0]          trap_bus_o;
  logic                         commit_valid_o;

  ysyx_041514_mem_wb dut (
    .clk(clk), .rst(rst),
    .stall_valid_i(stall_valid_i), .flush_valid_i(flush_valid_i),
    .mem_valid_i(mem_valid_i), .pc_i(pc_i), .mem_data_i(mem_data_i),
    .exc_csr_data_i(exc_csr_data_i), .inst_data_i(inst_data_i),
    .rd_idx_i(rd_idx_i), .csr_addr_i(csr_addr_i),
    .exc_csr_valid_i(exc_csr_valid_i), .trap_bus_i(trap_bus_i),
    .load_valid_i(load_valid_i), .mem_data_ready_i(mem_data_ready_i),
    .rdata_buff_valid_o(rdata_buff_valid_o), .rdata_buff_o(rdata_buff_o),
    .pc_o(pc_o), .mem_data_o(mem_data_o), .exc_csr_data_o(exc_csr_data_o),
    .inst_data_o(inst_data_o), .rd_idx_o(rd_idx_o), .csr_addr_o(csr_addr_o),
    .exc_csr_valid_o(exc_csr_valid_o), .trap_bus_o(trap_bus_o),
    .commit_valid_o(commit_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic        mvalid;
    logic        load;
    logic        ready;
    logic [63:0] pc;
    logic [63:0] data;
    logic [4:0]  rd;
    logic [63:0] e_pc;
    logic [63:0] e_data;
    logic [4:0]  e_rd;
    logic [31:0] e_inst;
    logic        e_csrv;
    logic        e_commit;
    logic        e_bvalid;
    logic [63:0] e_bdata;
  } vec_t;

  localparam logic [31:0] INST_T = 32'h00a0_0093;
  localparam logic [31:0] NOP_T  = 32'h0000_0013;

  vec_t vecs[14];

  task automatic idle_inputs();
    stall_valid_i    = 1'b0;
    flush_valid_i    = 1'b0;
    mem_valid_i      = 1'b0;
    pc_i             = '0;
    mem_data_i       = '0;
    exc_csr_data_i   = 64'h0000_0000_0000_0abc;
    inst_data_i      = INST_T;
    rd_idx_i         = '0;
    csr_addr_i       = 12'h300;
    exc_csr_valid_i  = 1'b1;
    trap_bus_i       = 8'h05;
    load_valid_i     = 1'b0;
    mem_data_ready_i = 1'b0;
  endtask

  int exp_commits;
  int got_commits;
  int cyc_limit;

  initial begin
    //          stall flush mv  ld  rdy pc            data          rd   e_pc          e_data        e_rd e_inst  csrv cm bv  bdata
    vecs[0]  = '{0, 0, 1, 0, 0, 64'h8000_0004, 64'h55,        5'd5, 64'h8000_0004, 64'h55,        5'd5, INST_T, 1, 1, 0, 64'h0};
    vecs[1]  = '{0, 0, 1, 0, 0, 64'h8000_0008, 64'h66,        5'd6, 64'h8000_0008, 64'h66,        5'd6, INST_T, 1, 1, 0, 64'h0};
    vecs[2]  = '{0, 0, 0, 0, 0, 64'h8000_000c, 64'h77,        5'd7, 64'h8000_000c, 64'h77,        5'd7, INST_T, 1, 0, 0, 64'h0};
    vecs[3]  = '{1, 0, 1, 1, 1, 64'h8000_0010, 64'hDEAD_BEEF, 5'd9, 64'h8000_000c, 64'h77,        5'd7, INST_T, 1, 0, 1, 64'hDEAD_BEEF};
    vecs[4]  = '{1, 0, 1, 1, 1, 64'h8000_0010, 64'h1234,      5'd9, 64'h8000_000c, 64'h77,        5'd7, INST_T, 1, 0, 1, 64'hDEAD_BEEF};
    vecs[5]  = '{1, 0, 1, 1, 0, 64'h8000_0010, 64'h1234,      5'd9, 64'h8000_000c, 64'h77,        5'd7, INST_T, 1, 0, 1, 64'hDEAD_BEEF};
    vecs[6]  = '{0, 0, 1, 1, 1, 64'h8000_0014, 64'h88,        5'd8, 64'h8000_0014, 64'h88,        5'd8, INST_T, 1, 1, 0, 64'h0};
    vecs[7]  = '{1, 0, 1, 1, 1, 64'h8000_0018, 64'hAAAA,      5'd3, 64'h8000_0014, 64'h88,        5'd8, INST_T, 1, 0, 1, 64'hAAAA};
    vecs[8]  = '{0, 1, 1, 1, 1, 64'h8000_0018, 64'hBBBB,      5'd3, 64'h0,         64'h0,         5'd0, NOP_T,  0, 0, 0, 64'h0};
    vecs[9]  = '{1, 0, 1, 1, 0, 64'h8000_001c, 64'hCCCC,      5'd4, 64'h0,         64'h0,         5'd0, NOP_T,  0, 0, 0, 64'h0};
    vecs[10] = '{1, 0, 1, 0, 1, 64'h8000_001c, 64'hCCCC,      5'd4, 64'h0,         64'h0,         5'd0, NOP_T,  0, 0, 0, 64'h0};
    vecs[11] = '{1, 1, 1, 1, 1, 64'h8000_001c, 64'hDDDD,      5'd4, 64'h0,         64'h0,         5'd0, NOP_T,  0, 0, 0, 64'h0};
    vecs[12] = '{0, 0, 1, 0, 0, 64'h8000_0020, 64'h99,        5'd10,64'h8000_0020, 64'h99,        5'd10,INST_T, 1, 1, 0, 64'h0};
    vecs[13] = '{1, 0, 0, 0, 0, 64'h8000_0024, 64'h11,        5'd11,64'h8000_0020, 64'h99,        5'd10,INST_T, 1, 0, 0, 64'h0};

    idle_inputs();
    rst = 1'b1;
    #12;
    check("reset_pc", pc_o, 64'h0);
    check("reset_inst", {32'h0, inst_data_o}, {32'h0, NOP_T});
    check("reset_bvalid", {63'h0, rdata_buff_valid_o}, 64'h0);
    check("reset_commit", {63'h0, commit_valid_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table: drive at negedge, check 1 time unit after the posedge
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      stall_valid_i    = vecs[i].stall;
      flush_valid_i    = vecs[i].flush;
      mem_valid_i      = vecs[i].mvalid;
      load_valid_i     = vecs[i].load;
      mem_data_ready_i = vecs[i].ready;
      pc_i             = vecs[i].pc;
      mem_data_i       = vecs[i].data;
      rd_idx_i         = vecs[i].rd;
      @(posedge clk);
      #1;
      $display("vec %0d: pc=%0h data=%0h rd=%0d commit=%0b bvalid=%0b bdata=%0h",
               i, pc_o, mem_data_o, rd_idx_o, commit_valid_o, rdata_buff_valid_o, rdata_buff_o);
      check($sformatf("v%0d_pc", i), pc_o, vecs[i].e_pc);
      check($sformatf("v%0d_data", i), mem_data_o, vecs[i].e_data);
      check($sformatf("v%0d_rd", i), {59'h0, rd_idx_o}, {59'h0, vecs[i].e_rd});
      check($sformatf("v%0d_inst", i), {32'h0, inst_data_o}, {32'h0, vecs[i].e_inst});
      check($sformatf("v%0d_csrv", i), {63'h0, exc_csr_valid_o}, {63'h0, vecs[i].e_csrv});
      check($sformatf("v%0d_commit", i), {63'h0, commit_valid_o}, {63'h0, vecs[i].e_commit});
      check($sformatf("v%0d_bvalid", i), {63'h0, rdata_buff_valid_o}, {63'h0, vecs[i].e_bvalid});
      check($sformatf("v%0d_bdata", i), rdata_buff_o, vecs[i].e_bdata);
    end

    // Asynchronous reset in the middle of a stall with a full buffer
    @(negedge clk);
    stall_valid_i    = 1'b1;
    load_valid_i     = 1'b1;
    mem_data_ready_i = 1'b1;
    mem_data_i       = 64'h5A5A;
    @(posedge clk);
    #1;
    check("midstall_fill", {63'h0, rdata_buff_valid_o}, 64'h1);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset: pc=%0h inst=%0h bvalid=%0b", pc_o, inst_data_o, rdata_buff_valid_o);
    check("async_rst_bvalid", {63'h0, rdata_buff_valid_o}, 64'h0);
    check("async_rst_bdata", rdata_buff_o, 64'h0);
    check("async_rst_pc", pc_o, 64'h0);
    check("async_rst_inst", {32'h0, inst_data_o}, {32'h0, NOP_T});
    check("async_rst_csrv", {63'h0, exc_csr_valid_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    // Random stall/flush stream: count commits against advance edges with mem_valid_i
    exp_commits = 0;
    got_commits = 0;
    cyc_limit   = 10000;
    for (int c = 0; c < cyc_limit; c++) begin
      @(negedge clk);
      stall_valid_i    = ($urandom_range(0, 9) < 3);
      flush_valid_i    = ($urandom_range(0, 9) == 0);
      mem_valid_i      = $urandom_range(0, 1) == 1;
      load_valid_i     = $urandom_range(0, 1) == 1;
      mem_data_ready_i = $urandom_range(0, 1) == 1;
      pc_i             = {32'h0, $urandom};
      mem_data_i       = {32'h0, $urandom};
      if (!stall_valid_i && !flush_valid_i && mem_valid_i) exp_commits++;
      @(posedge clk);
      #1;
      if (commit_valid_o) got_commits++;
    end
    $display("random stream: commits=%0d expected=%0d", got_commits, exp_commits);
    check("random_commit_count", 64'(got_commits), 64'(exp_commits));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
